// File: rtl/button_debouncer.sv
// Per-channel two-flop synchronizer and counter-based debouncer for board push buttons.
// Drives glitch-free levels to the button PIO plus one-cycle press/release strobes.
module button_debouncer #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter logic        RESET_LEVEL   = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_clean,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] busy
);

  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             PressLevel = ~ACTIVE_LOW;

  if (STABLE_CYCLES < 1 || (64'(1) << CNT_W) < 64'(STABLE_CYCLES)) begin : gen_param_check
    $error("button_debouncer: STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Any sample matching the accepted level clears the count: no partial credit.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]     = '0;
      clean_d[i]   = clean_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          clean_d[i]   = sync2_q[i];
          press_d[i]   = (sync2_q[i] == PressLevel);
          release_d[i] = (sync2_q[i] != PressLevel);
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= {WIDTH{RESET_LEVEL}};
      sync2_q   <= {WIDTH{RESET_LEVEL}};
      clean_q   <= {WIDTH{RESET_LEVEL}};
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign btn_clean     = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: per-edge vector table plus hand-written corner sequences.
module tb_button_debouncer;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_clean, press_pulse, release_pulse, busy;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .WIDTH        (2),
    .CNT_W        (3),
    .STABLE_CYCLES(4),
    .RESET_LEVEL  (1'b1),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_raw      (btn_raw),
    .btn_clean    (btn_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] clean;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] r, c, p, rl, b);
    vec_t v;
    v.raw = r; v.clean = c; v.press = p; v.rel = rl; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] c, p, rl, b);
    cmp({tag, " btn_clean"}, btn_clean, c);
    cmp({tag, " press_pulse"}, press_pulse, p);
    cmp({tag, " release_pulse"}, release_pulse, rl);
    cmp({tag, " busy"}, busy, b);
  endtask

  // Drive raw, take one edge, sample 1 time unit later.
  task automatic step(input string tag, input logic [1:0] r, c, p, rl, b);
    btn_raw = r;
    @(posedge clk);
    #1;
    check_all(tag, c, p, rl, b);
  endtask

  task automatic idle(input logic [1:0] r, input int n);
    btn_raw = r;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    // Test 1 from reset with both pins low, then test 2 release of ch0.
    for (int e = 0; e < 7; e++) begin
      add(2'b00, (e >= 5) ? 2'b00 : 2'b11, (e == 5) ? 2'b11 : 2'b00, 2'b00,
          (e >= 2 && e <= 4) ? 2'b11 : 2'b00);
    end
    for (int e = 0; e < 7; e++) begin
      add(2'b01, (e >= 5) ? 2'b01 : 2'b00, 2'b00, (e == 5) ? 2'b01 : 2'b00,
          (e >= 2 && e <= 4) ? 2'b01 : 2'b00);
    end
    for (int e = 0; e < 7; e++) begin
      add(2'b11, (e >= 5) ? 2'b11 : 2'b01, 2'b00, (e == 5) ? 2'b10 : 2'b00,
          (e >= 2 && e <= 4) ? 2'b10 : 2'b00);
    end
    // Test 3: ch1 glitch low for 3 samples, never accepted.
    for (int e = 0; e < 7; e++) begin
      add((e < 3) ? 2'b01 : 2'b11, 2'b11, 2'b00, 2'b00,
          (e >= 2 && e <= 4) ? 2'b10 : 2'b00);
    end

    reset_n = 1'b0;
    btn_raw = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'b11, 2'b00, 2'b00, 2'b00);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].raw, tbl[i].clean, tbl[i].press, tbl[i].rel,
           tbl[i].busy);
    end

    // Test 4: ch0 toggles for 10 samples then holds low.
    for (int g = 0; g < 10; g++) begin
      step($sformatf("toggle%0d", g), (g % 2 == 0) ? 2'b10 : 2'b11, 2'b11, 2'b00, 2'b00,
           (g >= 2 && g % 2 == 0) ? 2'b01 : 2'b00);
    end
    for (int g = 10; g < 17; g++) begin
      step($sformatf("hold%0d", g), 2'b10, (g >= 15) ? 2'b10 : 2'b11,
           (g == 15) ? 2'b01 : 2'b00, 2'b00, (g == 10 || (g >= 12 && g <= 14)) ? 2'b01 : 2'b00);
    end

    // Test 5: ch0 pressed, ch1 pressed two samples later.
    idle(2'b11, 8);
    check_all("t5 idle", 2'b11, 2'b00, 2'b00, 2'b00);
    step("t5 h0", 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    step("t5 h1", 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    step("t5 h2", 2'b00, 2'b11, 2'b00, 2'b00, 2'b01);
    step("t5 h3", 2'b00, 2'b11, 2'b00, 2'b00, 2'b01);
    step("t5 h4", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
    step("t5 h5", 2'b00, 2'b10, 2'b01, 2'b00, 2'b10);
    step("t5 h6", 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
    step("t5 h7", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    step("t5 h8", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Test 6: reset mid-count aborts, then full latency after release.
    idle(2'b11, 8);
    check_all("t6 idle", 2'b11, 2'b00, 2'b00, 2'b00);
    step("t6 k0", 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    step("t6 k1", 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    step("t6 k2", 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);
    reset_n = 1'b0;
    #1;
    check_all("t6 in reset", 2'b11, 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    check_all("t6 reset edge", 2'b11, 2'b00, 2'b00, 2'b00);
    reset_n = 1'b1;
    for (int m = 0; m < 7; m++) begin
      step($sformatf("t6 m%0d", m), 2'b10, (m >= 5) ? 2'b10 : 2'b11,
           (m == 5) ? 2'b01 : 2'b00, 2'b00, (m >= 2 && m <= 4) ? 2'b01 : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
